// File: rtl/argmax_tree_n.sv
// Pipelined N-channel argmax: masked unsigned inputs reduced by a registered
// binary comparator tree, one register stage per level, lowest index wins ties.
module argmax_tree_n #(
  parameter int P_WIDTH = 19,
  parameter int P_NUM   = 4,
  parameter int P_IDXW  = $clog2(P_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [P_NUM*P_WIDTH-1:0] i_data,
  input  logic [P_NUM-1:0]         i_mask,
  input  logic [P_WIDTH-1:0]       i_thresh,
  output logic                     o_valid,
  output logic [P_WIDTH-1:0]       o_result,
  output logic [P_NUM-1:0]         o_index,
  output logic [P_IDXW-1:0]        o_index_bin,
  output logic                     o_none,
  output logic                     o_hit
);

  localparam int L = $clog2(P_NUM);

  // Number of live entries entering tree level lvl (ceil(P_NUM / 2^lvl)).
  function automatic int level_cnt(input int lvl);
    return (P_NUM + (1 << lvl) - 1) >> lvl;
  endfunction

  logic [P_WIDTH-1:0] in_val     [P_NUM];
  logic [P_IDXW-1:0]  in_idx     [P_NUM];

  logic [P_WIDTH-1:0] val_next   [L][P_NUM];
  logic [P_IDXW-1:0]  idx_next   [L][P_NUM];
  logic [P_WIDTH-1:0] val_reg    [L][P_NUM];
  logic [P_IDXW-1:0]  idx_reg    [L][P_NUM];

  logic               stage_vin  [L];
  logic [P_WIDTH-1:0] stage_tin  [L];
  logic               valid_reg  [L];
  logic [P_WIDTH-1:0] thresh_reg [L];

  logic               none_reg;
  logic               hit_reg;
  logic [P_NUM-1:0]   onehot_reg;

  logic               fin_none;
  logic               fin_hit;
  logic [P_NUM-1:0]   fin_onehot;

  for (genvar gi = 0; gi < P_NUM; gi++) begin : g_in
    assign in_val[gi] = i_mask[gi] ? i_data[gi*P_WIDTH +: P_WIDTH] : '0;
    assign in_idx[gi] = P_IDXW'(gi);
  end

  for (genvar gl = 0; gl < L; gl++) begin : g_lvl
    localparam int N_SRC = level_cnt(gl);
    localparam int N_DST = level_cnt(gl + 1);

    logic [P_WIDTH-1:0] src_val [P_NUM];
    logic [P_IDXW-1:0]  src_idx [P_NUM];

    if (gl == 0) begin : g_src_in
      assign src_val        = in_val;
      assign src_idx        = in_idx;
      assign stage_vin[gl]  = i_valid;
      assign stage_tin[gl]  = i_thresh;
    end else begin : g_src_reg
      assign src_val        = val_reg[gl-1];
      assign src_idx        = idx_reg[gl-1];
      assign stage_vin[gl]  = valid_reg[gl-1];
      assign stage_tin[gl]  = thresh_reg[gl-1];
    end

    for (genvar gi = 0; gi < P_NUM; gi++) begin : g_node
      if (gi < N_DST && (2*gi + 1) < N_SRC) begin : g_cmp
        // >= keeps the left (lower-index) entry on ties.
        logic keep_left;
        assign keep_left          = src_val[2*gi] >= src_val[2*gi+1];
        assign val_next[gl][gi]   = keep_left ? src_val[2*gi] : src_val[2*gi+1];
        assign idx_next[gl][gi]   = keep_left ? src_idx[2*gi] : src_idx[2*gi+1];
      end else if (gi < N_DST) begin : g_pass
        assign val_next[gl][gi]   = src_val[2*gi];
        assign idx_next[gl][gi]   = src_idx[2*gi];
      end else begin : g_idle
        assign val_next[gl][gi]   = '0;
        assign idx_next[gl][gi]   = '0;
      end
    end
  end

  // A zero maximum means no channel wins, regardless of threshold.
  assign fin_none   = (val_next[L-1][0] == '0);
  assign fin_hit    = !fin_none && (val_next[L-1][0] >= stage_tin[L-1]);
  assign fin_onehot = fin_none ? '0 : (P_NUM'(1) << idx_next[L-1][0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < L; j++) begin
        valid_reg[j]  <= 1'b0;
        thresh_reg[j] <= '0;
        for (int m = 0; m < P_NUM; m++) begin
          val_reg[j][m] <= '0;
          idx_reg[j][m] <= '0;
        end
      end
      none_reg   <= 1'b0;
      hit_reg    <= 1'b0;
      onehot_reg <= '0;
    end else begin
      for (int j = 0; j < L; j++) begin
        valid_reg[j] <= stage_vin[j] && !i_clear;
        if (stage_vin[j]) begin
          val_reg[j]    <= val_next[j];
          idx_reg[j]    <= idx_next[j];
          thresh_reg[j] <= stage_tin[j];
        end
      end
      if (stage_vin[L-1]) begin
        none_reg   <= fin_none;
        hit_reg    <= fin_hit;
        onehot_reg <= fin_onehot;
      end
    end
  end

  assign o_valid     = valid_reg[L-1];
  assign o_result    = val_reg[L-1][0];
  assign o_index_bin = idx_reg[L-1][0];
  assign o_index     = onehot_reg;
  assign o_none      = none_reg;
  assign o_hit       = hit_reg;

endmodule

// File: tb/tb_argmax_tree_n.sv
// Directed bench for argmax_tree_n: a 4-channel and a 5-channel instance
// checked against hand-computed results, latency, clear and reset behaviour.
module tb_argmax_tree_n;

  localparam int W = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         clear;

  logic         v4;
  logic [4*W-1:0] d4;
  logic [3:0]   m4;
  logic [W-1:0] t4;
  logic         ov4;
  logic [W-1:0] res4;
  logic [3:0]   idx4;
  logic [1:0]   bin4;
  logic         none4;
  logic         hit4;

  logic         v5;
  logic [5*W-1:0] d5;
  logic [4:0]   m5;
  logic [W-1:0] t5;
  logic         ov5;
  logic [W-1:0] res5;
  logic [4:0]   idx5;
  logic [2:0]   bin5;
  logic         none5;
  logic         hit5;

  int n_checks = 0;
  int n_errors = 0;

  argmax_tree_n #(.P_WIDTH(W), .P_NUM(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(v4),
    .i_data(d4), .i_mask(m4), .i_thresh(t4),
    .o_valid(ov4), .o_result(res4), .o_index(idx4), .o_index_bin(bin4),
    .o_none(none4), .o_hit(hit4)
  );

  argmax_tree_n #(.P_WIDTH(W), .P_NUM(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(v5),
    .i_data(d5), .i_mask(m5), .i_thresh(t5),
    .o_valid(ov5), .o_result(res5), .o_index(idx5), .o_index_bin(bin5),
    .o_none(none5), .o_hit(hit5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input string tag, input logic [W-1:0] a, b, c, d,
                      input logic [3:0] m, input logic [W-1:0] t,
                      input logic [W-1:0] e_res, input logic [3:0] e_idx,
                      input logic [1:0] e_bin, input logic e_none, input logic e_hit);
    v4 = 1'b1; d4 = {d, c, b, a}; m4 = m; t4 = t;
    step();
    v4 = 1'b0;
    check_eq($sformatf("%s_early", tag), 32'(ov4), 32'd0);
    step();
    check_eq($sformatf("%s_valid", tag), 32'(ov4), 32'd1);
    check_eq($sformatf("%s_res", tag), 32'(res4), 32'(e_res));
    check_eq($sformatf("%s_idx", tag), 32'(idx4), 32'(e_idx));
    check_eq($sformatf("%s_bin", tag), 32'(bin4), 32'(e_bin));
    check_eq($sformatf("%s_none", tag), 32'(none4), 32'(e_none));
    check_eq($sformatf("%s_hit", tag), 32'(hit4), 32'(e_hit));
    step();
    check_eq($sformatf("%s_pulse", tag), 32'(ov4), 32'd0);
  endtask

  task automatic run5(input string tag, input logic [W-1:0] a, b, c, d, e,
                      input logic [4:0] m, input logic [W-1:0] e_res,
                      input logic [4:0] e_idx, input logic [2:0] e_bin);
    v5 = 1'b1; d5 = {e, d, c, b, a}; m5 = m; t5 = '0;
    step();
    v5 = 1'b0;
    step();
    check_eq($sformatf("%s_early", tag), 32'(ov5), 32'd0);
    step();
    check_eq($sformatf("%s_valid", tag), 32'(ov5), 32'd1);
    check_eq($sformatf("%s_res", tag), 32'(res5), 32'(e_res));
    check_eq($sformatf("%s_idx", tag), 32'(idx5), 32'(e_idx));
    check_eq($sformatf("%s_bin", tag), 32'(bin5), 32'(e_bin));
    check_eq($sformatf("%s_none", tag), 32'(none5), 32'd0);
    step();
    check_eq($sformatf("%s_pulse", tag), 32'(ov5), 32'd0);
  endtask

  // Streaming vectors: sd[k][ch], maxima 10, 20, 30, 40 at channels 0, 1, 3, 2.
  logic [W-1:0] sd [4][4];
  logic [3:0]   s_idx [4];
  logic         s_hit [4];
  int           s_res [4];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    sd[0] = '{19'd10, 19'd3, 19'd0, 19'd1};
    sd[1] = '{19'd1, 19'd20, 19'd2, 19'd0};
    sd[2] = '{19'd0, 19'd0, 19'd5, 19'd30};
    sd[3] = '{19'd1, 19'd1, 19'd40, 19'd2};
    s_res = '{10, 20, 30, 40};
    s_idx = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    s_hit = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b1; clear = 1'b0;
    v4 = 1'b0; d4 = '0; m4 = 4'hF; t4 = '0;
    v5 = 1'b0; d5 = '0; m5 = 5'h1F; t5 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid4", 32'(ov4), 32'd0);
    check_eq("rst_res4", 32'(res4), 32'd0);
    check_eq("rst_idx4", 32'(idx4), 32'd0);
    check_eq("rst_bin4", 32'(bin4), 32'd0);
    check_eq("rst_none4", 32'(none4), 32'd0);
    check_eq("rst_hit4", 32'(hit4), 32'd0);
    check_eq("rst_valid5", 32'(ov5), 32'd0);
    check_eq("rst_idx5", 32'(idx5), 32'd0);
    #3 rst_n = 1'b1;
    step();

    run4("basic", 19'd5, 19'd12, 19'd300, 19'd7, 4'hF, 19'd0, 19'd300, 4'b0100, 2'd2, 1'b0, 1'b1);
    run4("tie_all", 19'd9, 19'd9, 19'd9, 19'd9, 4'hF, 19'd0, 19'd9, 4'b0001, 2'd0, 1'b0, 1'b1);
    run4("tie_bc", 19'd1, 19'd5, 19'd5, 19'd0, 4'hF, 19'd0, 19'd5, 4'b0010, 2'd1, 1'b0, 1'b1);
    run4("mask", 19'd0, 19'd0, 19'd50, 19'd100, 4'b0111, 19'd0, 19'd50, 4'b0100, 2'd2, 1'b0, 1'b1);
    run4("zero", 19'd0, 19'd0, 19'd0, 19'd0, 4'hF, 19'd0, 19'd0, 4'b0000, 2'd0, 1'b1, 1'b0);
    run4("mask_zero", 19'd0, 19'd0, 19'd0, 19'd500, 4'b0111, 19'd0, 19'd0, 4'b0000, 2'd0, 1'b1, 1'b0);
    run4("thr_eq", 19'd25, 19'd3, 19'd1, 19'd2, 4'hF, 19'd25, 19'd25, 4'b0001, 2'd0, 1'b0, 1'b1);
    run4("thr_above", 19'd25, 19'd3, 19'd1, 19'd2, 4'hF, 19'd26, 19'd25, 4'b0001, 2'd0, 1'b0, 1'b0);
    run4("fullw", 19'h7FFFE, 19'd0, 19'd0, 19'h7FFFF, 4'hF, 19'h7FFFF, 19'h7FFFF, 4'b1000, 2'd3, 1'b0, 1'b1);

    // Back-to-back stream with a common threshold.
    m4 = 4'hF; t4 = 19'd25;
    for (int k = 0; k < 4; k++) begin
      v4 = 1'b1;
      d4 = {sd[k][3], sd[k][2], sd[k][1], sd[k][0]};
      step();
      if (k == 0) begin
        check_eq("strm_early", 32'(ov4), 32'd0);
      end else begin
        check_eq($sformatf("strm%0d_valid", k-1), 32'(ov4), 32'd1);
        check_eq($sformatf("strm%0d_res", k-1), 32'(res4), 32'(s_res[k-1]));
        check_eq($sformatf("strm%0d_idx", k-1), 32'(idx4), 32'(s_idx[k-1]));
        check_eq($sformatf("strm%0d_hit", k-1), 32'(hit4), 32'(s_hit[k-1]));
      end
    end
    v4 = 1'b0;
    step();
    check_eq("strm3_valid", 32'(ov4), 32'd1);
    check_eq("strm3_res", 32'(res4), 32'(s_res[3]));
    check_eq("strm3_idx", 32'(idx4), 32'(s_idx[3]));
    check_eq("strm3_hit", 32'(hit4), 32'(s_hit[3]));
    step();
    check_eq("strm_end", 32'(ov4), 32'd0);

    // Clear: vector 1 flushed in flight, vector 2 dropped, vector 3 survives.
    t4 = '0;
    v4 = 1'b1; d4 = {19'd0, 19'd0, 19'd11, 19'd0};
    step();
    d4 = {19'd22, 19'd0, 19'd0, 19'd0}; clear = 1'b1;
    check_eq("clr_e1", 32'(ov4), 32'd0);
    step();
    clear = 1'b0; d4 = {19'd0, 19'd33, 19'd0, 19'd0};
    check_eq("clr_e2", 32'(ov4), 32'd0);
    step();
    v4 = 1'b0;
    check_eq("clr_e3", 32'(ov4), 32'd0);
    step();
    check_eq("clr_v3_valid", 32'(ov4), 32'd1);
    check_eq("clr_v3_res", 32'(res4), 32'd33);
    check_eq("clr_v3_idx", 32'(idx4), 32'b0100);
    step();
    check_eq("clr_e5", 32'(ov4), 32'd0);

    // Asynchronous reset while a result is valid and another is in flight.
    v4 = 1'b1; d4 = {19'd0, 19'd0, 19'd0, 19'd77};
    step();
    d4 = {19'd88, 19'd0, 19'd0, 19'd0};
    step();
    v4 = 1'b0;
    check_eq("pre_rst_valid", 32'(ov4), 32'd1);
    check_eq("pre_rst_res", 32'(res4), 32'd77);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(ov4), 32'd0);
    check_eq("mid_rst_res", 32'(res4), 32'd0);
    check_eq("mid_rst_idx", 32'(idx4), 32'd0);
    check_eq("mid_rst_hit", 32'(hit4), 32'd0);
    check_eq("mid_rst_none", 32'(none4), 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    v4 = 1'b1; d4 = {19'd0, 19'd99, 19'd0, 19'd0};
    step();
    v4 = 1'b0;
    check_eq("post_rst_early", 32'(ov4), 32'd0);
    step();
    check_eq("post_rst_valid", 32'(ov4), 32'd1);
    check_eq("post_rst_res", 32'(res4), 32'd99);
    check_eq("post_rst_idx", 32'(idx4), 32'b0100);
    step();
    check_eq("post_rst_pulse", 32'(ov4), 32'd0);

    // Five channels: odd entry passes through, latency 3.
    run5("n5_top", 19'd1, 19'd1, 19'd1, 19'd1, 19'h7FFFF, 5'h1F, 19'h7FFFF, 5'b10000, 3'd4);
    run5("n5_tie", 19'd3, 19'd3, 19'd3, 19'd3, 19'd3, 5'h1F, 19'd3, 5'b00001, 3'd0);
    run5("n5_tie04", 19'd50, 19'd10, 19'd10, 19'd10, 19'd50, 5'h1F, 19'd50, 5'b00001, 3'd0);
    run5("n5_mask", 19'd1, 19'd2, 19'd3, 19'd2, 19'h7FFFF, 5'b01111, 19'd3, 5'b00100, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/argmax_tree_n.md
Name: argmax_tree_n

Overview:
- Parametrised N-channel argmax: finds the largest of P_NUM unsigned P_WIDTH values and returns the maximum, a one-hot winner index and a binary winner index.
- Pipelined comparator tree with one register stage per tree level. Accepts one vector per clock and has a valid pipeline.
- Adds per-channel masking, a threshold hit flag and a synchronous flush.
- Sits after the neuron dot-product / similarity outputs, feeding winner-take-all selection and label logic.

Parameters:
- P_WIDTH, 19: bit width of each channel value (unsigned).
- P_NUM, 4: number of channels, 2..64. Need not be a power of two.
- P_IDXW, $clog2(P_NUM): width of the binary index output (derived; do not override).

Ports:
- i_clk  in  1  clock; all registers update on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush; kills all in-flight valids.
- i_valid  in  1  input vector valid.
- i_data  in  P_NUM*P_WIDTH  packed channels; channel k at bits [k*P_WIDTH +: P_WIDTH].
- i_mask  in  P_NUM  1 = channel participates; 0 = channel forced to value 0.
- i_thresh  in  P_WIDTH  minimum winning value for o_hit; sampled with i_valid.
- o_valid  out  1  result valid.
- o_result  out  P_WIDTH  maximum value (masked channels excluded).
- o_index  out  P_NUM  one-hot winner; all-zero when no winner.
- o_index_bin  out  P_IDXW  binary winner index; 0 when no winner.
- o_none  out  1  1 when every effective channel is 0 (no winner).
- o_hit  out  1  1 when a winner exists and o_result >= the sampled i_thresh.

Behaviour:
- Reset: every pipeline register, including all outputs, is cleared to 0 asynchronously. While i_rst_n = 0, o_valid = 0.
- Latency: L = $clog2(P_NUM) cycles. Example: a vector sampled on edge t with i_valid = 1 appears with o_valid = 1 after edge t+L-1. For P_NUM = 4, L = 2; for P_NUM = 5, L = 3.
- Throughput: one vector per cycle. There is no backpressure and no stall; the pipeline always advances.
- Tree level j, pair (2m, 2m+1):
  - Keep the left entry if left.value >= right.value, otherwise keep the right entry.
  - The winner carries its value and its original channel index.
  - An odd leftover entry at a level passes through its register unchanged.
- Tie rule: on equal values the lowest channel index wins at every level, so the lowest index wins globally.
- Masking: an effective value is i_mask[k] ? channel k : 0, applied before level 0.
- No-winner case: all effective values are 0. Then o_result = 0, o_index = 0, o_index_bin = 0, o_none = 1, o_hit = 0.
  - This holds even if i_thresh = 0.
  - A zero-valued channel never wins.
- o_hit: when o_none = 0, o_hit = (o_result >= thresh). The thresh value travels down the pipeline with its vector.
- Bubbles: when the stage valid is 0, that stage's data registers hold their previous contents. Outputs other than o_valid are don't-care to consumers when o_valid = 0, but they must not be X after reset.
- i_clear:
  - On the next edge, all stage valid bits clear.
  - A vector presented with i_valid = 1 in the same cycle is dropped.
  - The data registers need not clear.
- i_clear has no effect on reset behaviour. Asynchronous reset mid-stream drops all in-flight vectors. The first valid vector after deassertion emerges L cycles after it is sampled.
- Arithmetic: unsigned compare, full width, no saturation. o_index is exactly one-hot whenever o_none = 0.

Test Plan:
- P_NUM=4, P_WIDTH=19, mask=4'hF, thresh=0, data {d=7, c=300, b=12, a=5} with valid for one cycle -> after 2 cycles: o_valid=1, o_result=300, o_index=4'b0100, o_index_bin=2, o_none=0, o_hit=1.
- Ties: data {9, 9, 9, 9} -> o_result=9, o_index=4'b0001, o_index_bin=0. Data {0, 5, 5, 1} (a=1, b=5, c=5, d=0) -> o_index=4'b0010.
- Masking and zero:
  - Data {100, 50, 0, 0}, mask=4'b0111 -> o_result=50, o_index=4'b0100.
  - All-zero data -> o_none=1, o_index=0, o_hit=0, o_result=0.
- Threshold and streaming: 4 back-to-back vectors with maxima 10, 20, 30, 40 and thresh 25 each -> 4 consecutive o_valid cycles with o_hit = 0, 0, 1, 1 in order.
- Non-power-of-two: P_NUM=5, channel 4 = 0x7FFFF, all others 1 -> after 3 cycles: o_index=5'b10000, o_index_bin=4, o_result=0x7FFFF.
- Clear and reset:
  - Stream 3 vectors and assert i_clear on the 2nd -> only the vector sampled after clear ever produces o_valid. Vector 1 is flushed in flight and vector 2 is dropped at input.
  - Pull i_rst_n low mid-stream -> all outputs go to 0 immediately. A vector sent after release emerges after exactly L cycles.
